// File: rtl/tff_counter_gen.sv
// rtl/tff_counter_gen.sv - loadable multi-mode counter (up/down/bounce/Gray)
// with a registered one-cycle terminal-count pulse and bounce direction flag.
module tff_counter_gen #(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 10,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load_n,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             dir_up
);

  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;
  logic             r_tc;
  logic             r_dir;

  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;
  logic             w_in_range;
  logic             w_d_in_range;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_tc_nxt;
  logic             w_dir_nxt;

  assign w_inc        = r_cnt + ONE;
  assign w_dec        = r_cnt - ONE;
  // Compare one bit wider so MODULUS = 2^WIDTH never reads as out of range.
  assign w_in_range   = {1'b0, r_cnt} < MOD_W;
  assign w_d_in_range = {1'b0, d} < MOD_W;
  assign w_load_val   = (mode == 2'b11 || w_d_in_range) ? d : TOP;

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_tc_nxt  = 1'b0;
    w_dir_nxt = r_dir;
    if (!load_n) begin
      w_cnt_nxt = w_load_val;
      w_dir_nxt = !(mode == 2'b10 && w_load_val == TOP);
    end else if (en) begin
      case (mode)
        2'b00: begin
          if (!w_in_range) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == TOP) begin
            w_cnt_nxt = '0;
            w_tc_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = w_inc;
          end
        end
        2'b01: begin
          if (!w_in_range) begin
            w_cnt_nxt = TOP;
          end else if (r_cnt == '0) begin
            w_cnt_nxt = TOP;
            w_tc_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = w_dec;
          end
        end
        2'b10: begin
          if (!w_in_range) begin
            w_cnt_nxt = r_dir ? '0 : TOP;
          end else if (r_dir) begin
            // Already at the top while heading up (entered from another mode): turn around.
            if (r_cnt == TOP) begin
              w_cnt_nxt = w_dec;
              if (w_dec == '0) w_tc_nxt = 1'b1;
              else             w_dir_nxt = 1'b0;
            end else begin
              w_cnt_nxt = w_inc;
              if (w_inc == TOP) begin
                w_dir_nxt = 1'b0;
                w_tc_nxt  = 1'b1;
              end
            end
          end else begin
            if (r_cnt == '0) begin
              w_cnt_nxt = w_inc;
              if (w_inc == TOP) w_tc_nxt = 1'b1;
              else              w_dir_nxt = 1'b1;
            end else begin
              w_cnt_nxt = w_dec;
              if (w_dec == '0) begin
                w_dir_nxt = 1'b1;
                w_tc_nxt  = 1'b1;
              end
            end
          end
        end
        default: begin
          w_cnt_nxt = w_inc;
          w_tc_nxt  = (w_inc == '0);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= RST_V;
      r_tc  <= 1'b0;
      r_dir <= 1'b1;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_tc  <= w_tc_nxt;
      r_dir <= w_dir_nxt;
    end
  end

  assign q      = (mode == 2'b11) ? (r_cnt ^ (r_cnt >> 1)) : r_cnt;
  assign tc     = r_tc;
  assign dir_up = r_dir;

endmodule

// File: tb/tb_tff_counter_gen.sv
// tb/tb_tff_counter_gen.sv - directed plan plus randomized run against an integer reference model.
module tb_tff_counter_gen;

  localparam int W  = 4;
  localparam int M  = 10;
  localparam int RV = 0;

  logic         clk = 1'b0;
  logic         rst, en, load_n;
  logic [W-1:0] d;
  logic [1:0]   mode;
  logic [W-1:0] q;
  logic         tc, dir_up;

  int n_checks = 0;
  int n_errors = 0;

  int m_cnt = RV;
  int m_tc  = 0;
  int m_dir = 1;
  bit m_valid = 1'b0;

  tff_counter_gen #(.WIDTH(W), .MODULUS(M), .RESET_VALUE(RV)) dut (
    .clk(clk), .rst(rst), .en(en), .load_n(load_n), .d(d), .mode(mode),
    .q(q), .tc(tc), .dir_up(dir_up)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the count value, from the behaviour rules.
  always @(posedge clk) begin
    int v;
    if (rst) begin
      m_cnt = RV; m_tc = 0; m_dir = 1; m_valid = 1'b1;
    end else if (!load_n) begin
      v = int'(d);
      if (mode != 2'b11 && v >= M) v = M - 1;
      m_cnt = v; m_tc = 0;
      m_dir = (mode == 2'b10 && v == M - 1) ? 0 : 1;
    end else if (!en) begin
      m_tc = 0;
    end else begin
      m_tc = 0;
      case (mode)
        2'b00: if (m_cnt >= M) m_cnt = 0;
               else if (m_cnt == M - 1) begin m_cnt = 0; m_tc = 1; end
               else m_cnt = m_cnt + 1;
        2'b01: if (m_cnt >= M) m_cnt = M - 1;
               else if (m_cnt == 0) begin m_cnt = M - 1; m_tc = 1; end
               else m_cnt = m_cnt - 1;
        2'b10: begin
          if (m_cnt >= M) m_cnt = m_dir ? 0 : M - 1;
          else begin
            if (m_dir == 1 && m_cnt == M - 1) m_dir = 0;
            else if (m_dir == 0 && m_cnt == 0) m_dir = 1;
            m_cnt = m_dir ? m_cnt + 1 : m_cnt - 1;
            if (m_cnt == M - 1) begin m_dir = 0; m_tc = 1; end
            else if (m_cnt == 0) begin m_dir = 1; m_tc = 1; end
          end
        end
        default: begin
          m_cnt = (m_cnt + 1) % (1 << W);
          m_tc  = (m_cnt == 0) ? 1 : 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_q", int'(q), (mode == 2'b11) ? (m_cnt ^ (m_cnt >> 1)) : m_cnt);
      chk("model_tc", int'(tc), m_tc);
      chk("model_dir_up", int'(dir_up), m_dir);
    end
  end

  task automatic adv(input string nm, input int eq, input int etc);
    @(posedge clk);
    #1;
    chk({nm, "_q"}, int'(q), eq);
    chk({nm, "_tc"}, int'(tc), etc);
  endtask

  int exp_up[11]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
  int exp_dn[8]    = '{6, 5, 4, 3, 2, 1, 0, 9};
  int exp_bn[20]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
  int exp_gray[16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

  initial begin
    rst = 1'b1; load_n = 1'b1; en = 1'b0; mode = 2'b00; d = '0;
    adv("reset", 0, 0);
    chk("reset_dir_up", int'(dir_up), 1);

    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      adv("up", exp_up[i], (i == 9) ? 1 : 0);
      chk("up_dir_up", int'(dir_up), 1);
    end

    en = 1'b0; load_n = 1'b0; d = 4'd7;
    adv("load7", 7, 0);
    load_n = 1'b1; mode = 2'b01; en = 1'b1;
    for (int i = 0; i < 8; i++) adv("down", exp_dn[i], (i == 7) ? 1 : 0);

    rst = 1'b1;
    adv("rst_bounce", 0, 0);
    rst = 1'b0; mode = 2'b10;
    for (int i = 0; i < 20; i++) begin
      adv("bounce", exp_bn[i], (i == 8 || i == 17) ? 1 : 0);
      if (i == 8)  chk("bounce_dir_fall", int'(dir_up), 0);
      if (i == 17) chk("bounce_dir_rise", int'(dir_up), 1);
    end

    rst = 1'b1; mode = 2'b11;
    adv("rst_gray", 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) adv("gray", exp_gray[i], (i == 15) ? 1 : 0);
    mode = 2'b00;
    adv("gray_to_up", 1, 0);

    en = 1'b0; load_n = 1'b0; d = 4'd12;
    adv("load12_clamp", 9, 0);
    load_n = 1'b1; en = 1'b1;
    adv("clamp_wrap", 0, 1);
    en = 1'b0; load_n = 1'b0; mode = 2'b11;
    adv("load12_gray", 10, 0);
    load_n = 1'b1; mode = 2'b01; en = 1'b1;
    adv("oor_down", 9, 0);

    rst = 1'b1; load_n = 1'b0; d = 4'd5; mode = 2'b00;
    adv("rst_over_load", 0, 0);
    rst = 1'b0; en = 1'b0;
    adv("load5_noen", 5, 0);
    load_n = 1'b1;
    for (int i = 0; i < 4; i++) adv("hold", 5, 0);

    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      rst    = ($urandom_range(0, 59) == 0);
      load_n = ($urandom_range(0, 9) != 0);
      en     = ($urandom_range(0, 3) != 0);
      d      = W'($urandom_range(0, (1 << W) - 1));
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
    end
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
